// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request arbiter: size encodings, FSM state
// type and a helper that sizes channel-index fields.
package mem_arb_pkg;

  // Access size encodings carried on req_size / mc_len.
  localparam logic [1:0]  SZ_BYTE       = 2'd0;
  localparam logic [1:0]  SZ_HALF       = 2'd1;
  localparam logic [1:0]  SZ_WORD       = 2'd2;
  localparam int unsigned SZ_SIGNED_BIT = 2;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_e;

  // Width of a channel index; a single-channel build still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational request picker. It returns the first eligible channel at or
// after the search start. Fixed mode starts at 0. Round-robin mode starts one
// past the last grant.
module rr_picker
  import mem_arb_pkg::*;
#(
  parameter int unsigned NCH = 3
) (
  input  logic [NCH-1:0]        eligible,
  input  logic [idx_w(NCH)-1:0] last_grant,
  input  logic                  rr_mode,
  output logic [idx_w(NCH)-1:0] grant,
  output logic                  any
);

  localparam int unsigned GW = idx_w(NCH);

  int unsigned    start;
  logic [NCH-1:0] rot;

  // Rotate the mask so the search start sits at bit 0, then take the first set bit.
  always_comb begin
    any   = 1'b0;
    grant = '0;
    start = rr_mode ? ((32'(last_grant) + 32'd1) % NCH) : 32'd0;
    rot   = NCH'({eligible, eligible} >> start);
    for (int unsigned i = 0; i < NCH; i++) begin
      if (!any && rot[i]) begin
        any   = 1'b1;
        grant = GW'((start + i) % NCH);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// N-channel memory request arbiter in front of the byte-serial memory
// controller. It grants one latched request at a time, returns the result with
// a one-cycle ready pulse, and on flush kills speculative reads on masked
// channels while letting writes finish.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned    NCH        = 3,
  parameter int unsigned    ADDR_W     = 32,
  parameter int unsigned    DATA_W     = 32,
  parameter int unsigned    RR_MODE    = 0,
  parameter logic [NCH-1:0] FLUSH_MASK = {NCH{1'b1}}
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic                  flush,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH-1:0]        req_wr,
  input  logic [3*NCH-1:0]      req_size,
  input  logic [ADDR_W*NCH-1:0] req_addr,
  input  logic [DATA_W*NCH-1:0] req_wdata,
  output logic [NCH-1:0]        req_ready,
  output logic [DATA_W-1:0]     req_rdata,
  output logic                  mc_valid,
  output logic                  mc_wr,
  output logic [ADDR_W-1:0]     mc_addr,
  output logic [2:0]            mc_len,
  output logic [DATA_W-1:0]     mc_data,
  input  logic                  mc_ready,
  input  logic [DATA_W-1:0]     mc_res,
  output logic                  mc_abort
);

  localparam int unsigned GW = idx_w(NCH);

  arb_state_e        state_q, state_d;
  logic [GW-1:0]     grant_q, grant_d;
  logic [GW-1:0]     last_q, last_d;
  logic              mc_wr_q, mc_wr_d;
  logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
  logic [2:0]        mc_len_q, mc_len_d;
  logic [DATA_W-1:0] mc_data_q, mc_data_d;
  logic              abort_q, abort_d;

  logic [NCH-1:0]    eligible;
  logic [NCH-1:0]    grant_oh;
  logic [GW-1:0]     pick;
  logic              pick_any;
  logic              sel_wr;
  logic [2:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              busy;
  logic              kill;
  logic              done;

  assign eligible = req_valid & ~(flush ? FLUSH_MASK : '0);

  rr_picker #(
    .NCH(NCH)
  ) u_picker (
    .eligible  (eligible),
    .last_grant(last_q),
    .rr_mode   (RR_MODE != 0),
    .grant     (pick),
    .any       (pick_any)
  );

  // Select the picked channel's request fields for latching.
  always_comb begin
    sel_wr   = 1'b0;
    sel_size = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (pick == GW'(i)) begin
        sel_wr   = req_wr[i];
        sel_size = req_size[i*3 +: 3];
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Decode the held grant index to one-hot for ready steering and flush masking.
  always_comb begin
    grant_oh = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      grant_oh[i] = (grant_q == GW'(i));
    end
  end

  assign busy = (state_q == ARB_BUSY);
  // Only reads on flushable channels are speculative; writes always retire.
  assign kill = busy & flush & ~mc_wr_q & |(grant_oh & FLUSH_MASK);
  assign done = busy & mc_ready & rdy_in & ~kill;

  assign req_ready = done ? grant_oh : '0;
  assign req_rdata = mc_res;
  assign mc_valid  = busy;
  assign mc_wr     = mc_wr_q;
  assign mc_addr   = mc_addr_q;
  assign mc_len    = mc_len_q;
  assign mc_data   = mc_data_q;
  assign mc_abort  = abort_q & rdy_in;

  // Next-state logic: grant from IDLE, complete or abort from BUSY, hold while paused.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    mc_wr_d   = mc_wr_q;
    mc_addr_d = mc_addr_q;
    mc_len_d  = mc_len_q;
    mc_data_d = mc_data_q;
    abort_d   = abort_q;
    if (rdy_in) begin
      abort_d = 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            state_d   = ARB_BUSY;
            grant_d   = pick;
            last_d    = pick;
            mc_wr_d   = sel_wr;
            mc_addr_d = sel_addr;
            mc_len_d  = sel_size;
            mc_data_d = sel_data;
          end
        end
        ARB_BUSY: begin
          if (kill) begin
            state_d = ARB_IDLE;
            abort_d = 1'b1;
          end else if (mc_ready) begin
            state_d = ARB_IDLE;
          end
        end
        default: state_d = ARB_IDLE;
      endcase
    end
  end

  // State and latched request registers.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ARB_IDLE;
      grant_q   <= '0;
      last_q    <= GW'(NCH - 1);
      mc_wr_q   <= 1'b0;
      mc_addr_q <= '0;
      mc_len_q  <= '0;
      mc_data_q <= '0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      mc_wr_q   <= mc_wr_d;
      mc_addr_q <= mc_addr_d;
      mc_len_q  <= mc_len_d;
      mc_data_q <= mc_data_d;
      abort_q   <= abort_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a fixed-priority instance with ch2 outside the
// flush mask, and a round-robin instance with the default mask.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        flush;
  logic [2:0]  req_wr;
  logic [8:0]  req_size;
  logic [95:0] req_addr;
  logic [95:0] req_wdata;

  logic [2:0]  a_req_valid, a_req_ready;
  logic [31:0] a_req_rdata, a_mc_addr, a_mc_data, a_mc_res;
  logic        a_mc_valid, a_mc_wr, a_mc_ready, a_mc_abort;
  logic [2:0]  a_mc_len;

  logic [2:0]  b_req_valid, b_req_ready;
  logic [31:0] b_req_rdata, b_mc_addr, b_mc_data, b_mc_res;
  logic        b_mc_valid, b_mc_wr, b_mc_ready, b_mc_abort;
  logic [2:0]  b_mc_len;

  int total = 0;
  int bad   = 0;

  logic [2:0] sz0, sz1, sz2;

  always #5 clk_in = ~clk_in;

  mem_arbiter #(
    .NCH(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .FLUSH_MASK(3'b011)
  ) dut_fix (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .req_valid(a_req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(a_req_ready), .req_rdata(a_req_rdata),
    .mc_valid(a_mc_valid), .mc_wr(a_mc_wr), .mc_addr(a_mc_addr),
    .mc_len(a_mc_len), .mc_data(a_mc_data),
    .mc_ready(a_mc_ready), .mc_res(a_mc_res), .mc_abort(a_mc_abort)
  );

  mem_arbiter #(
    .NCH(3), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .FLUSH_MASK(3'b111)
  ) dut_rr (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush(flush),
    .req_valid(b_req_valid), .req_wr(req_wr), .req_size(req_size),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(b_req_ready), .req_rdata(b_req_rdata),
    .mc_valid(b_mc_valid), .mc_wr(b_mc_wr), .mc_addr(b_mc_addr),
    .mc_len(b_mc_len), .mc_data(b_mc_data),
    .mc_ready(b_mc_ready), .mc_res(b_mc_res), .mc_abort(b_mc_abort)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs are then changed away from the edge.
  task automatic tick();
    @(posedge clk_in);
    #2;
  endtask

  // One round-robin transaction on dut_rr with all channels held valid.
  task automatic rr_step(input string tag, input logic [31:0] exp_addr,
                         input logic [2:0] exp_ready);
    tick();
    check({tag, " valid"}, 32'(b_mc_valid), 32'd1);
    check({tag, " addr"}, b_mc_addr, exp_addr);
    b_mc_ready = 1'b1;
    #1;
    check({tag, " ready"}, 32'(b_req_ready), 32'(exp_ready));
    tick();
    b_mc_ready = 1'b0;
    #1;
    check({tag, " ready drop"}, 32'(b_req_ready), 32'd0);
    check({tag, " bubble"}, 32'(b_mc_valid), 32'd0);
  endtask

  initial begin
    sz0 = {1'b0, SZ_WORD};
    sz1 = 3'b000;
    sz1[SZ_SIGNED_BIT] = 1'b1;
    sz1[1:0] = SZ_HALF;
    sz2 = {1'b0, SZ_BYTE};

    rst_in      = 1'b1;
    rdy_in      = 1'b1;
    flush       = 1'b0;
    req_wr      = 3'b000;
    req_size    = {sz2, sz1, sz0};
    req_addr    = {32'h0000_3000, 32'h0000_2000, 32'h0000_1000};
    req_wdata   = {32'h0000_00C2, 32'h0000_00B1, 32'h0000_00A0};
    a_req_valid = 3'b000;
    a_mc_ready  = 1'b0;
    a_mc_res    = 32'h0;
    b_req_valid = 3'b000;
    b_mc_ready  = 1'b0;
    b_mc_res    = 32'h0;

    #3;
    check("rst mc_valid", 32'(a_mc_valid), 32'd0);
    check("rst mc_wr", 32'(a_mc_wr), 32'd0);
    check("rst mc_addr", a_mc_addr, 32'd0);
    check("rst mc_len", 32'(a_mc_len), 32'd0);
    check("rst mc_data", a_mc_data, 32'd0);
    check("rst req_ready", 32'(a_req_ready), 32'd0);
    check("rst mc_abort", 32'(a_mc_abort), 32'd0);
    tick();
    rst_in = 1'b0;

    // Round-robin: all held valid, expect 0,1,2,0.
    b_req_valid = 3'b111;
    rr_step("rr g0", 32'h0000_1000, 3'b001);
    rr_step("rr g1", 32'h0000_2000, 3'b010);
    rr_step("rr g2", 32'h0000_3000, 3'b100);
    rr_step("rr g0b", 32'h0000_1000, 3'b001);
    b_req_valid = 3'b000;
    tick();

    // Fixed priority: ch0 and ch1 together, ch0 first.
    a_req_valid = 3'b011;
    tick();
    check("fix g0 valid", 32'(a_mc_valid), 32'd1);
    check("fix g0 addr", a_mc_addr, 32'h0000_1000);
    check("fix g0 len", 32'(a_mc_len), 32'(3'b010));
    check("fix g0 ready idle", 32'(a_req_ready), 32'd0);
    a_mc_res   = 32'hDEAD_BEEF;
    a_mc_ready = 1'b1;
    #1;
    check("fix g0 ready", 32'(a_req_ready), 32'(3'b001));
    check("fix g0 rdata", a_req_rdata, 32'hDEAD_BEEF);
    tick();
    a_req_valid = 3'b010;
    a_mc_ready  = 1'b0;
    check("fix bubble", 32'(a_mc_valid), 32'd0);
    tick();
    check("fix g1 valid", 32'(a_mc_valid), 32'd1);
    check("fix g1 addr", a_mc_addr, 32'h0000_2000);
    check("fix g1 len", 32'(a_mc_len), 32'(3'b101));
    a_mc_ready = 1'b1;
    #1;
    check("fix g1 ready", 32'(a_req_ready), 32'(3'b010));
    tick();
    a_req_valid = 3'b000;
    a_mc_ready  = 1'b0;
    tick();

    // Flush kills a ch1 read even with mc_ready high; ch2 write waits.
    req_wr      = 3'b100;
    a_req_valid = 3'b010;
    tick();
    check("abort busy", 32'(a_mc_valid), 32'd1);
    a_req_valid = 3'b110;
    flush       = 1'b1;
    a_mc_ready  = 1'b1;
    #1;
    check("abort no ready", 32'(a_req_ready), 32'd0);
    check("abort not yet", 32'(a_mc_abort), 32'd0);
    tick();
    flush       = 1'b0;
    a_mc_ready  = 1'b0;
    a_req_valid = 3'b100;
    #1;
    check("abort pulse", 32'(a_mc_abort), 32'd1);
    check("abort valid low", 32'(a_mc_valid), 32'd0);
    tick();
    check("abort one cycle", 32'(a_mc_abort), 32'd0);
    check("ch2 valid", 32'(a_mc_valid), 32'd1);
    check("ch2 addr", a_mc_addr, 32'h0000_3000);
    check("ch2 wr", 32'(a_mc_wr), 32'd1);
    check("ch2 data", a_mc_data, 32'h0000_00C2);
    a_mc_ready = 1'b1;
    #1;
    check("ch2 ready", 32'(a_req_ready), 32'(3'b100));
    tick();
    a_req_valid = 3'b000;
    a_mc_ready  = 1'b0;

    // Flush masks a flushable channel while idle.
    a_req_valid = 3'b001;
    flush       = 1'b1;
    tick();
    check("flush idle no grant", 32'(a_mc_valid), 32'd0);
    flush = 1'b0;
    tick();
    check("post flush grant", 32'(a_mc_valid), 32'd1);
    a_mc_ready = 1'b1;
    tick();
    a_req_valid = 3'b000;
    a_mc_ready  = 1'b0;
    tick();

    // Flush during a ch1 write is ignored; latched fields ignore requester changes.
    req_wr      = 3'b010;
    req_addr    = {32'h0000_3000, 32'h0000_0100, 32'h0000_1000};
    req_wdata   = {32'h0000_00C2, 32'h0000_0055, 32'h0000_00A0};
    a_req_valid = 3'b010;
    tick();
    req_addr  = {32'h0000_3000, 32'h0000_0FFF, 32'h0000_1000};
    req_wdata = {32'h0000_00C2, 32'h0000_0077, 32'h0000_00A0};
    flush     = 1'b1;
    tick();
    check("wr flush no abort", 32'(a_mc_abort), 32'd0);
    check("wr still busy", 32'(a_mc_valid), 32'd1);
    check("wr addr held", a_mc_addr, 32'h0000_0100);
    check("wr data held", a_mc_data, 32'h0000_0055);
    a_mc_ready = 1'b1;
    #1;
    check("wr ready", 32'(a_req_ready), 32'(3'b010));
    tick();
    flush       = 1'b0;
    a_req_valid = 3'b000;
    a_mc_ready  = 1'b0;
    #1;
    check("wr no late abort", 32'(a_mc_abort), 32'd0);
    req_wr = 3'b000;
    tick();

    // rdy_in low freezes the transaction and suppresses ready.
    a_req_valid = 3'b001;
    tick();
    rdy_in     = 1'b0;
    a_mc_ready = 1'b1;
    #1;
    check("pause no ready", 32'(a_req_ready), 32'd0);
    tick();
    check("pause frozen", 32'(a_mc_valid), 32'd1);
    rdy_in = 1'b1;
    #1;
    check("resume ready", 32'(a_req_ready), 32'(3'b001));
    tick();
    a_req_valid = 3'b000;
    a_mc_ready  = 1'b0;
    tick();

    // Asynchronous reset mid-transaction.
    a_req_valid = 3'b001;
    tick();
    check("pre rst busy", 32'(a_mc_valid), 32'd1);
    a_mc_ready = 1'b1;
    rst_in     = 1'b1;
    #1;
    check("async rst valid", 32'(a_mc_valid), 32'd0);
    check("async rst ready", 32'(a_req_ready), 32'd0);
    check("async rst addr", a_mc_addr, 32'd0);
    tick();
    a_req_valid = 3'b000;
    a_mc_ready  = 1'b0;
    rst_in      = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Parametrised N-channel memory request arbiter that sits between the CPU's memory clients (instruction fetch, load/store unit, optional prefetcher) and the byte-serial `MemoryController`. It grants one latched request at a time, by fixed or round-robin priority, and drives the controller. It returns the result to the granted channel with a one-cycle ready pulse. On pipeline flush it aborts speculative reads on selected channels but lets in-flight writes complete.

## Interface
- `NCH`, 3: number of request channels; channel 0 is highest fixed priority.
- `ADDR_W`, 32: address width.
- `DATA_W`, 32: data width.
- `RR_MODE`, 0: 0 = fixed priority, 1 = round-robin.
- `FLUSH_MASK`, `{NCH{1'b1}}`: channels whose reads are killed by `flush`.

Ports:
- `clk_in` in 1: single clock.
- `rst_in` in 1: asynchronous, active-high reset.
- `rdy_in` in 1: global pause; low freezes all state.
- `flush` in 1: pipeline clear (ROB clear).
- `req_valid` in NCH: per-channel request, held until served.
- `req_wr` in NCH: 1 = write.
- `req_size` in 3*NCH: [1:0] 0 byte / 1 half / 2 word; [2] signed.
- `req_addr` in ADDR_W*NCH: per-channel address.
- `req_wdata` in DATA_W*NCH: per-channel write data.
- `req_ready` out NCH: one-hot completion pulse.
- `req_rdata` out DATA_W: shared result, valid with `req_ready`.
- `mc_valid` out 1: controller enable.
- `mc_wr` out 1: latched write flag.
- `mc_addr` out ADDR_W: latched address.
- `mc_len` out 3: latched size.
- `mc_data` out DATA_W: latched write data.
- `mc_ready` in 1: controller done.
- `mc_res` in DATA_W: controller result.
- `mc_abort` out 1: one-cycle pulse that resets the controller.

## Operation
- States: IDLE, BUSY.
- IDLE: if any eligible `req_valid`, pick channel g, latch `wr/size/addr/wdata[g]` into `mc_*` registers, set `grant=g`, go BUSY, assert `mc_valid`.
- Eligible = `req_valid & ~(flush ? FLUSH_MASK : 0)`.
- Fixed mode: lowest index wins.
- RR mode: search starts at `last_grant+1` modulo NCH; `last_grant` updates on every grant.
- BUSY: `mc_valid`=1 until `mc_ready`.
- `req_ready[grant] = BUSY & mc_ready & rdy_in`; `req_rdata = mc_res` pass-through. State returns to IDLE next edge and `mc_valid` drops.
- Flush in BUSY, granted read on a FLUSH_MASK channel: pulse `mc_abort`, go IDLE, no `req_ready`. This holds even if `mc_ready` is high that same cycle.
- Flush in BUSY, granted write, or channel not in FLUSH_MASK: ignored; the request completes normally.
- `rdy_in` low: no state change; `req_ready` and `mc_abort` forced 0.
- Latched fields are immune to requester changes after grant.
- Requesters keep `req_valid` until `req_ready` and must drop it the following cycle, otherwise they are regranted.

## Timing
- Reset values: state IDLE, `mc_valid`=0, `mc_wr`=0, `mc_addr`=0, `mc_len`=0, `mc_data`=0, `req_ready`=0, `mc_abort`=0, `grant`=0, `last_grant`=NCH-1 (so channel 0 is first in RR mode).
- Grant latency: `req_valid` sampled in cycle t gives `mc_valid` high in cycle t+1.
- `mc_ready` in cycle k gives `req_ready` in cycle k (combinational) and IDLE in k+1. The earliest next `mc_valid` is in k+2, one bubble.
- `mc_abort` is registered: asserted in the cycle after flush is sampled, for exactly one cycle. `mc_valid` is 0 in that cycle.
- Asynchronous reset mid-transaction drops `mc_valid` immediately. No `req_ready` is produced.
- Single-channel build (NCH=1) is legal; the picker degenerates to a pass.

## Structure
- Shared package `mem_arb_pkg`:
  - size encodings `SZ_BYTE=2'd0`, `SZ_HALF=2'd1`, `SZ_WORD=2'd2`, `SZ_SIGNED_BIT=2`;
  - state enum `{ARB_IDLE, ARB_BUSY}`.
- One sub-module, `rr_picker`: combinational; inputs eligible mask, `last_grant`, mode; outputs grant index and any-flag.

## Test plan
- NCH=3 fixed mode, ch0 and ch1 valid in the same cycle -> ch0 granted. `mc_addr` = ch0 address next cycle; ch1 is granted in k+2 after ch0's `req_ready`.
- RR mode, all three channels held valid -> grant sequence 0,1,2,0. Each `req_ready` pulse is exactly 1 cycle.
- Granted read on ch0 with `mc_res=0xDEADBEEF` -> `req_ready`=3'b001, `req_rdata=0xDEADBEEF` in the same cycle.
- Flush while a ch1 read is BUSY -> `mc_abort` pulses once, no `req_ready`. A ch2 write pending in the same cycle is granted only after flush deasserts, provided ch2 is outside FLUSH_MASK.
- Flush while a ch1 write (addr 0x100, data 0x55) is BUSY -> no abort. The write completes and `req_ready[1]` pulses.
- `rdy_in` held low across `mc_ready` -> no `req_ready`. Assert `rst_in` mid-BUSY -> `mc_valid`=0 before the next clock edge.
